ws2812_bit_encoder: RTL and testbench

//  Downstream of the 24-bit pixel shift register. Requests one serial pixel bit at a

---
 rtl/ws2812_bit_encoder_pkg.sv | 35 +++
 rtl/ws2812_bit_encoder_if.sv | 40 ++++
 rtl/ws2812_bit_encoder_cycle_counter.sv | 31 +++
 rtl/ws2812_bit_encoder.sv | 169 ++++++++++++++++
 tb/tb_ws2812_bit_encoder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_bit_encoder_pkg.sv
// rtl/ws2812_bit_encoder_pkg.sv - default timing constants, state encoding and width helpers
package ws2812_bit_encoder_pkg;

  // Default frame geometry: 8x8 snake matrix, GRB words sent MSB first.
  localparam int DEF_W      = 24;
  localparam int DEF_N_LEDS = 64;

  // Default pulse timing in clk cycles at 50 MHz.
  localparam int DEF_T0H_CYC   = 20;     // 0.40 us high for a '0'
  localparam int DEF_T1H_CYC   = 40;     // 0.80 us high for a '1'
  localparam int DEF_BIT_CYC   = 63;     // 1.26 us full bit period
  localparam int DEF_RESET_CYC = 14000;  // 280 us latch gap

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_FETCH = 3'd2,
    ST_BIT   = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  // Index width that never collapses to zero bits when only one value exists.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Cycle counter width: must hold the larger of the bit period and the latch gap.
  function automatic int cyc_width(input int bit_cyc, input int reset_cyc);
    int m;
    m = (bit_cyc > reset_cyc) ? bit_cyc : reset_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder_if.sv
// rtl/ws2812_bit_encoder_if.sv - frame control, bit request and LED line signals
interface ws2812_bit_encoder_if
  import ws2812_bit_encoder_pkg::*;
#(
  parameter int N_LEDS = DEF_N_LEDS
);

  localparam int IDX_W = width_of(N_LEDS);

  logic             frame_start;
  logic             bit_in;
  logic             bit_req;
  logic [IDX_W-1:0] led_idx;
  logic             led_dout;
  logic             busy;
  logic             frame_done;

  // Encoder side: consumes frame requests and serial bits, drives the line.
  modport master (
    input  frame_start,
    input  bit_in,
    output bit_req,
    output led_idx,
    output led_dout,
    output busy,
    output frame_done
  );

  // Upstream side: starts frames and answers bit requests.
  modport slave (
    output frame_start,
    output bit_in,
    input  bit_req,
    input  led_idx,
    input  led_dout,
    input  busy,
    input  frame_done
  );

endinterface

// File: rtl/ws2812_bit_encoder_cycle_counter.sv
// rtl/ws2812_bit_encoder_cycle_counter.sv - loadable up-counter with terminal-count flag
module ws2812_bit_encoder_cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  // Load wins over enable so a period boundary restarts cleanly at load_val.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign count = cnt;
  assign tc    = (cnt == limit);

endmodule

// File: rtl/ws2812_bit_encoder.sv
// rtl/ws2812_bit_encoder.sv - WS2812 pulse-width bit encoder with frame and latch sequencing
module ws2812_bit_encoder
  import ws2812_bit_encoder_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int N_LEDS    = DEF_N_LEDS,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int RESET_CYC = DEF_RESET_CYC
) (
  input logic                  clk,
  input logic                  rst_n,
  ws2812_bit_encoder_if.master bus
);

  localparam int CYC_W = cyc_width(BIT_CYC, RESET_CYC);
  localparam int BIT_W = width_of(W);
  localparam int IDX_W = width_of(N_LEDS);

  // Cycle positions inside a bit period and the latch gap.
  localparam logic [CYC_W-1:0] CYC_BIT_LAST   = CYC_W'(BIT_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_REQ        = CYC_W'(BIT_CYC - 2);
  localparam logic [CYC_W-1:0] CYC_LATCH_LAST = CYC_W'(RESET_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_T0H        = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] CYC_T1H        = CYC_W'(T1H_CYC);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LEDS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             cur_bit;
  logic [BIT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] led_idx;
  logic             frame_done_r;

  logic             cnt_load;
  logic             cnt_en;
  logic [CYC_W-1:0] cyc;
  logic [CYC_W-1:0] cyc_limit;
  logic             cyc_tc;

  logic             last_bit;
  logic             advance;
  logic             bit_req;
  logic             led_dout;

  // The final bit of the frame suppresses the look-ahead request and leads to LATCH.
  assign last_bit = (bit_cnt == BIT_LAST) && (led_idx == IDX_LAST);

  // Moving on to another bit of the same frame at the end of a bit period.
  assign advance = (state == ST_BIT) && cyc_tc && !last_bit;

  // One counter times both the bit period and the latch gap; only the limit differs.
  assign cyc_limit = (state == ST_LATCH) ? CYC_LATCH_LAST : CYC_BIT_LAST;

  ws2812_bit_encoder_cycle_counter #(
    .WIDTH (CYC_W)
  ) u_cycle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .limit    (cyc_limit),
    .count    (cyc),
    .tc       (cyc_tc)
  );

  // State register; async reset drops the line through the combinational outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter control, request strobe and line level.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    bit_req   = 1'b0;
    led_dout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_nxt = ST_PRIME;
        end
      end
      ST_PRIME: begin
        bit_req   = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        cnt_load  = 1'b1;
        state_nxt = ST_BIT;
      end
      ST_BIT: begin
        led_dout = (cyc < (cur_bit ? CYC_T1H : CYC_T0H));
        // Request two cycles ahead so the next bit is registered at cyc=BIT_CYC-1.
        bit_req  = (cyc == CYC_REQ) && !last_bit;
        if (cyc_tc) begin
          cnt_load = 1'b1;
          if (last_bit) begin
            state_nxt = ST_LATCH;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_LATCH: begin
        if (cyc_tc) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the requested bit the cycle after each bit_req strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_bit <= 1'b0;
    end else if ((state == ST_FETCH) || advance) begin
      cur_bit <= bus.bit_in;
    end
  end

  // Bit and LED position; the LED index moves with the first bit of the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      led_idx <= '0;
    end else if ((state == ST_IDLE) && bus.frame_start) begin
      bit_cnt <= '0;
      led_idx <= '0;
    end else if (advance) begin
      if (bit_cnt == BIT_LAST) begin
        bit_cnt <= '0;
        led_idx <= led_idx + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Completion pulse lands on the first IDLE cycle after the latch gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= (state == ST_LATCH) && cyc_tc;
    end
  end

  assign bus.bit_req    = bit_req;
  assign bus.led_dout   = led_dout;
  assign bus.led_idx    = led_idx;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// tb/tb_ws2812_bit_encoder.sv - directed self-checking bench for ws2812_bit_encoder
module tb_ws2812_bit_encoder;

  localparam int MAXS = 120;

  logic clk = 1'b0;
  logic rst_n;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic       tr_dout [MAXS];
  logic       tr_req  [MAXS];
  logic [0:0] tr_idx  [MAXS];
  logic       tr_busy [MAXS];
  logic       tr_done [MAXS];
  int nsamp;
  int done_idx;
  int rise [16];
  int width [16];
  int req [16];
  int nrise;
  int nreq;

  ws2812_bit_encoder_if #(.N_LEDS(2)) bus ();

  ws2812_bit_encoder #(
    .W         (4),
    .N_LEDS    (2),
    .T0H_CYC   (2),
    .T1H_CYC   (4),
    .BIT_CYC   (8),
    .RESET_CYC (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic capture(input logic [7:0] bits, input int pa, input int pb,
                         input int abort_at, input bit b2b, input bit skip_start);
    int ptr;
    bit seen;
    ptr = 0;
    seen = 0;
    nsamp = 0;
    done_idx = MAXS - 1;
    for (int i = 0; i < MAXS; i++) begin
      tr_dout[i] = 0; tr_req[i] = 0; tr_idx[i] = '0; tr_busy[i] = 0; tr_done[i] = 0;
    end
    if (!skip_start) begin
      @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
    end
    for (int i = 0; i < MAXS; i++) begin
      tr_dout[i] = bus.led_dout;
      tr_req[i]  = bus.bit_req;
      tr_idx[i]  = bus.led_idx;
      tr_busy[i] = bus.busy;
      tr_done[i] = bus.frame_done;
      nsamp = i + 1;
      if (bus.bit_req) begin
        if (ptr < 8) bus.bit_in = bits[3'(7 - ptr)];
        ptr++;
      end
      bus.frame_start = (i == pa) || (i == pb);
      if (bus.frame_done) begin
        seen = 1;
        done_idx = i;
        if (b2b) bus.frame_start = 1'b1;
        break;
      end
      if (i == abort_at) break;
      @(negedge clk);
    end
    if (b2b && seen) @(negedge clk);
    bus.frame_start = 1'b0;
    if (abort_at < 0) begin
      total_cnt++;
      if (!seen) $display("FAIL frame_done_timeout: got no frame_done within %0d cycles, required one", MAXS);
      else pass_cnt++;
    end
  endtask

  task automatic analyze();
    nrise = 0;
    nreq = 0;
    for (int k = 0; k < 16; k++) begin
      rise[k] = 0; width[k] = 0; req[k] = 0;
    end
    for (int i = 0; i < nsamp; i++) begin
      if (tr_dout[i] && (i == 0 || !tr_dout[i-1])) begin
        if (nrise < 16) rise[nrise] = i;
        nrise++;
      end
      if (tr_dout[i] && nrise > 0 && nrise <= 16) width[nrise-1]++;
      if (tr_req[i]) begin
        if (nreq < 16) req[nreq] = i;
        nreq++;
      end
    end
  endtask

  task automatic test_reset();
    total_cnt++;
    if (bus.led_dout !== 1'b0) $display("FAIL reset_dout: got %b expected 0", bus.led_dout); else pass_cnt++;
    total_cnt++;
    if (bus.bit_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", bus.bit_req); else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.frame_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.frame_done); else pass_cnt++;
    total_cnt++;
    if (bus.led_idx !== 1'b0) $display("FAIL reset_idx: got %0d expected 0", bus.led_idx); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.led_dout !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%b dout=%b expected 0/0", bus.busy, bus.led_dout);
    else pass_cnt++;
  endtask

  task automatic check_shape(input string tag, input int expw[8]);
    total_cnt++;
    if (nrise !== 8) $display("FAIL %s_pulses: got %0d expected 8", tag, nrise); else pass_cnt++;
    total_cnt++;
    if (nreq !== 8) $display("FAIL %s_bit_req_count: got %0d expected 8", tag, nreq); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if (width[k] !== expw[k]) $display("FAIL %s_width[%0d]: got %0d expected %0d", tag, k, width[k], expw[k]);
      else pass_cnt++;
      total_cnt++;
      if (rise[k] !== 2 + 8 * k) $display("FAIL %s_rise[%0d]: got cycle %0d expected %0d", tag, k, rise[k], 2 + 8 * k);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_idx !== 86) $display("FAIL %s_done_cycle: got %0d expected 86", tag, done_idx); else pass_cnt++;
  endtask

  task automatic test_frame();
    int expw[8];
    int late;
    expw = '{4, 2, 4, 2, 2, 4, 4, 2};
    capture(8'b10100110, -1, -1, -1, 1'b0, 1'b0);
    analyze();
    check_shape("frame", expw);
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if (rise[k] - req[k] !== 2) $display("FAIL req_to_rise[%0d]: got %0d cycles expected 2", k, rise[k] - req[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (tr_idx[rise[3]] !== 1'b0) $display("FAIL idx_bit4: got %0d expected 0", tr_idx[rise[3]]); else pass_cnt++;
    total_cnt++;
    if (tr_idx[rise[4]-1] !== 1'b0) $display("FAIL idx_before_bit5: got %0d expected 0", tr_idx[rise[4]-1]); else pass_cnt++;
    total_cnt++;
    if (tr_idx[rise[4]] !== 1'b1) $display("FAIL idx_bit5: got %0d expected 1", tr_idx[rise[4]]); else pass_cnt++;
    late = 0;
    for (int i = rise[7]; i < nsamp; i++) if (tr_req[i]) late++;
    total_cnt++;
    if (late !== 0) $display("FAIL req_after_last: got %0d expected 0", late); else pass_cnt++;
    total_cnt++;
    if (done_idx - (rise[7] + 8) !== 20) $display("FAIL latch_gap: got %0d expected 20", done_idx - (rise[7] + 8));
    else pass_cnt++;
    total_cnt++;
    if (tr_busy[done_idx] !== 1'b0) $display("FAIL busy_at_done: got %b expected 0", tr_busy[done_idx]); else pass_cnt++;
    total_cnt++;
    if (tr_busy[done_idx-1] !== 1'b1) $display("FAIL busy_before_done: got %b expected 1", tr_busy[done_idx-1]); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.frame_done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", bus.frame_done); else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int expw[8];
    expw = '{4, 2, 4, 2, 2, 4, 4, 2};
    capture(8'b10100110, 21, 70, -1, 1'b0, 1'b0);
    analyze();
    check_shape("ignore", expw);
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL ignore_restarted: got busy=%b expected 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int expw[8];
    expw = '{4, 4, 4, 4, 4, 4, 4, 4};
    capture(8'b10100110, -1, -1, 43, 1'b0, 1'b0);
    total_cnt++;
    if (tr_dout[43] !== 1'b1) $display("FAIL mid_high_before_reset: got %b expected 1", tr_dout[43]); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.led_dout !== 1'b0) $display("FAIL mid_reset_dout: got %b expected 0", bus.led_dout); else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.bit_req !== 1'b0 || bus.frame_done !== 1'b0)
      $display("FAIL mid_reset_outputs: got busy=%b req=%b done=%b expected 0/0/0", bus.busy, bus.bit_req, bus.frame_done);
    else pass_cnt++;
    total_cnt++;
    if (bus.led_idx !== 1'b0) $display("FAIL mid_reset_idx: got %0d expected 0", bus.led_idx); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture(8'hFF, -1, -1, -1, 1'b0, 1'b0);
    analyze();
    check_shape("restart", expw);
    total_cnt++;
    if (tr_idx[2] !== 1'b0) $display("FAIL restart_idx: got %0d expected 0", tr_idx[2]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int expw[8];
    expw = '{4, 4, 2, 2, 2, 2, 4, 4};
    capture(8'b01011100, -1, -1, -1, 1'b1, 1'b0);
    total_cnt++;
    if (done_idx !== 86) $display("FAIL b2b_first_done: got %0d expected 86", done_idx); else pass_cnt++;
    total_cnt++;
    if (bus.bit_req !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL b2b_prime: got req=%b busy=%b expected 1/1", bus.bit_req, bus.busy);
    else pass_cnt++;
    capture(8'b11000011, -1, -1, -1, 1'b0, 1'b1);
    analyze();
    check_shape("b2b", expw);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.bit_in = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_frame();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
